// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified memory port arbiter.
package mem_arb_pkg;

  // Which requester owns the response that is in flight.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int STARVE_W   = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals of the arbiter.
// slave  : the arbiter's view (takes requests, drives grants/responses/memory port).
// master : the surrounding core/memory view.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  localparam int STRB_W = DATA_W / 8;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_we;
  logic [STRB_W-1:0] d_wstrb;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] m_addr;
  logic              m_we;
  logic [STRB_W-1:0] m_wstrb;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_we, d_wstrb, d_wdata, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_addr, m_we, m_wstrb, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, d_we, d_wstrb, d_wdata, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_addr, m_we, m_wstrb, m_wdata
  );

endinterface

// File: rtl/mem_arb_select.sv
// Combinational one-hot grant selection between fetch and data requesters.
// RR_EN = 0: data wins a conflict unless the starvation limit is hit.
// RR_EN = 1: the requester not granted last wins a conflict.
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter bit RR_EN = 1'b0
) (
  input  logic rst_i,
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic starve_hit_i,  // fetch has been denied the maximum number of cycles
  input  logic rr_last_i,     // 1 = fetch was granted last, 0 = data was
  output logic i_gnt_o,
  output logic d_gnt_o
);

  logic fetch_wins;

  // Resolve conflicts and gate every grant with reset.
  always_comb begin
    fetch_wins = RR_EN ? ~rr_last_i : starve_hit_i;
    i_gnt_o    = ~rst_i & i_req_i & (~d_req_i | fetch_wins);
    d_gnt_o    = ~rst_i & d_req_i & ~(i_req_i & fetch_wins);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory address/data port between instruction fetch and load/store.
// One access per cycle, registered response with fixed 1-cycle latency.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to replace data priority with
// the starvation counter by alternating round-robin arbitration.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int STRB_W = DATA_W / 8;

  logic i_gnt;
  logic d_gnt;
  logic starve_hit;
  logic rr_last;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;

  logic rr_last_q, rr_last_d;

  // Remember which requester got the port most recently.
  always_comb begin
    rr_last_d = rr_last_q;
    if (i_gnt) begin
      rr_last_d = 1'b1;
    end else if (d_gnt) begin
      rr_last_d = 1'b0;
    end
  end

  // Round-robin state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q <= 1'b0;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

  assign rr_last    = rr_last_q;
  assign starve_hit = 1'b0;
`else
  localparam bit RR_EN = 1'b0;
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

  // Count consecutive cycles in which fetch asks but is refused; saturate at the limit.
  always_comb begin
    starve_cnt_d = '0;
    if (bus.i_req && !i_gnt) begin
      starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? starve_cnt_q : starve_cnt_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign starve_hit = (starve_cnt_q == STARVE_LIM);
  assign rr_last    = 1'b0;
`endif

  mem_arb_select #(
    .RR_EN (RR_EN)
  ) u_select (
    .rst_i        (rst),
    .i_req_i      (bus.i_req),
    .d_req_i      (bus.d_req),
    .starve_hit_i (starve_hit),
    .rr_last_i    (rr_last),
    .i_gnt_o      (i_gnt),
    .d_gnt_o      (d_gnt)
  );

  // Response register: owner of the in-flight access plus per-port read data that
  // holds until that port's next response. A write completes with zero data.
  logic              rsp_vld_q, rsp_vld_d;
  owner_e            rsp_own_q, rsp_own_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  // Capture the access being granted this cycle.
  always_comb begin
    rsp_vld_d = i_gnt | d_gnt;
    rsp_own_d = d_gnt ? OWN_D : OWN_I;
    i_rdata_d = i_gnt ? bus.m_rdata : i_rdata_q;
    d_rdata_d = d_rdata_q;
    if (d_gnt) begin
      d_rdata_d = bus.d_we ? '0 : bus.m_rdata;
    end
  end

  // Response registers; reset drops any pending completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld_q <= 1'b0;
      rsp_own_q <= OWN_I;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      rsp_vld_q <= rsp_vld_d;
      rsp_own_q <= rsp_own_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  logic [ADDR_W-1:0] m_addr_mux;

  // Steer the granted requester onto the memory port; idle cycles present zeros.
  always_comb begin
    m_addr_mux = '0;
    if (i_gnt) begin
      m_addr_mux = bus.i_addr;
    end else if (d_gnt) begin
      m_addr_mux = bus.d_addr;
    end
  end

  assign bus.i_gnt    = i_gnt;
  assign bus.d_gnt    = d_gnt;
  assign bus.m_addr   = m_addr_mux;
  assign bus.m_we     = d_gnt & bus.d_we;
  assign bus.m_wstrb  = (d_gnt & bus.d_we) ? bus.d_wstrb : {STRB_W{1'b0}};
  assign bus.m_wdata  = bus.d_wdata;

  // Responses are suppressed while reset is held so nothing pending leaks out.
  assign bus.i_rvalid = ~rst & rsp_vld_q & (rsp_own_q == OWN_I);
  assign bus.d_rvalid = ~rst & rsp_vld_q & (rsp_own_q == OWN_D);
  assign bus.i_rdata  = rst ? '0 : i_rdata_q;
  assign bus.d_rdata  = rst ? '0 : d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a driver predicts grants and responses
// from the arbitration rules, a monitor pops expected responses as they appear.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory device driven by the DUT's port.
  logic [31:0] mem     [128];
  logic [31:0] ref_mem [128];

  assign bus.m_rdata = mem[bus.m_addr[8:2]];

  always @(posedge clk) begin
    if (bus.m_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.m_wstrb[b]) mem[bus.m_addr[8:2]][8*b +: 8] = bus.m_wdata[8*b +: 8];
      end
    end
  end

  typedef struct packed {
    logic        is_d;
    logic [31:0] data;
  } rsp_t;

  rsp_t q[$];

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference state: arbitration history and memory contents.
`ifdef MEM_ARB_ROUND_ROBIN_EN
  bit prefer_i = 1'b1;
`else
  int denied_run = 0;
`endif

  logic dut_igt;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    prefer_i = 1'b1;
`else
    denied_run = 0;
`endif
    q.delete();
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    mem[a[8:2]]     = v;
    ref_mem[a[8:2]] = v;
  endtask

  // One clock cycle of stimulus with predicted grants and memory-port values.
  task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                      input logic [3:0] ds, input logic [31:0] dwd, input logic [31:0] da,
                      output logic gi, output logic gd);
    logic fetch_first;
    rsp_t e;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus.i_req   = ir;
    bus.i_addr  = ia;
    bus.d_req   = dr;
    bus.d_we    = dwe;
    bus.d_wstrb = ds;
    bus.d_wdata = dwd;
    bus.d_addr  = da;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    fetch_first = prefer_i;
`else
    fetch_first = (denied_run >= STARVE_MAX);
`endif
    gi = ir && (!dr || fetch_first);
    gd = dr && !gi;
    #3;
    dut_igt = bus.i_gnt;
    chk("i_gnt", 32'(bus.i_gnt), 32'(gi));
    chk("d_gnt", 32'(bus.d_gnt), 32'(gd));
    chk("m_addr", bus.m_addr, gi ? ia : (gd ? da : 32'h0));
    chk("m_we", 32'(bus.m_we), 32'(gd && dwe));
    chk("m_wstrb", 32'(bus.m_wstrb), (gd && dwe) ? 32'(ds) : 32'h0);
    chk("m_wdata", bus.m_wdata, dwd);
    if (gi) begin
      e.is_d = 1'b0;
      e.data = ref_mem[ia[8:2]];
      q.push_back(e);
    end
    if (gd) begin
      e.is_d = 1'b1;
      e.data = dwe ? 32'h0 : ref_mem[da[8:2]];
      q.push_back(e);
      if (dwe) ref_mem[da[8:2]] = merge(ref_mem[da[8:2]], dwd, ds);
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (gi) prefer_i = 1'b0;
    else if (gd) prefer_i = 1'b1;
`else
    if (ir && !gi) denied_run = (denied_run < STARVE_MAX) ? denied_run + 1 : denied_run;
    else denied_run = 0;
`endif
  endtask

  // Reset cycles with both requests asserted: no grant may issue.
  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      rst        = 1'b1;
      bus.i_req  = 1'b1;
      bus.d_req  = 1'b1;
      bus.d_we   = 1'b1;
      bus.d_wstrb = 4'hF;
      model_reset();
      #3;
      chk("rst_i_gnt", 32'(bus.i_gnt), 32'h0);
      chk("rst_d_gnt", 32'(bus.d_gnt), 32'h0);
      chk("rst_m_addr", bus.m_addr, 32'h0);
      chk("rst_m_we", 32'(bus.m_we), 32'h0);
    end
  endtask

  // Monitor: compare each cycle's response outputs with the scoreboard.
  logic [31:0] exp_ir = 32'h0;
  logic [31:0] exp_dr = 32'h0;

  always @(posedge clk) begin
    rsp_t e;
    #3;
    if (rst) begin
      exp_ir = 32'h0;
      exp_dr = 32'h0;
      chk("rst_i_rvalid", 32'(bus.i_rvalid), 32'h0);
      chk("rst_d_rvalid", 32'(bus.d_rvalid), 32'h0);
    end else if (q.size() > 0) begin
      e = q.pop_front();
      if (e.is_d) exp_dr = e.data;
      else exp_ir = e.data;
      chk("i_rvalid", 32'(bus.i_rvalid), 32'(!e.is_d));
      chk("d_rvalid", 32'(bus.d_rvalid), 32'(e.is_d));
    end else begin
      chk("idle_i_rvalid", 32'(bus.i_rvalid), 32'h0);
      chk("idle_d_rvalid", 32'(bus.d_rvalid), 32'h0);
    end
    chk("i_rdata", bus.i_rdata, exp_ir);
    chk("d_rdata", bus.d_rdata, exp_dr);
  end

  function automatic logic [31:0] rnd_addr();
    logic [6:0] idx;
    idx = 7'($urandom_range(0, 127));
    return 32'h8000_0000 | {23'h0, idx, 2'b00};
  endfunction

  initial begin
    logic gi, gd;
    logic ip, dp, dwe;
    logic [3:0] ds;
    logic [31:0] ia, da, dwd;
    int n_igt;

    bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_addr = '0;
    bus.d_we = 1'b0; bus.d_wstrb = '0; bus.d_wdata = '0;
    for (int k = 0; k < 128; k++) begin
      mem[k]     = 32'h0;
      ref_mem[k] = 32'h0;
    end
    for (int k = 0; k < 128; k++) preload(32'h8000_0000 + 32'(k * 4), $urandom);

    do_reset(3);

    // Fetch only.
    preload(32'h8000_0000, 32'h0000_0013);
    step(1'b1, 32'h8000_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd);
    step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd);

    // Conflict: both requesting for ten cycles.
    n_igt = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 32'h8000_0000 + 32'(k * 4), 1'b1, 1'b0, 4'h0, 32'h0, 32'h8000_0100, gi, gd);
      if (dut_igt) n_igt++;
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("conflict_fetch_grants", 32'(n_igt), 32'd5);
`else
    chk("conflict_fetch_grants", 32'(n_igt), 32'd2);
`endif
    step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd);

    // Write then read the same word on consecutive cycles.
    step(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h8000_0040, gi, gd);
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h8000_0040, gi, gd);

    // Byte strobe merge.
    preload(32'h8000_0044, 32'h1122_3344);
    step(1'b0, 32'h0, 1'b1, 1'b1, 4'h2, 32'h0000_AB00, 32'h8000_0044, gi, gd);
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h8000_0044, gi, gd);
    chk("strobe_merge_mem", mem[7'h11], 32'h1122_AB44);

    // Reset right after a granted read: the response must vanish.
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h8000_0008, gi, gd);
    do_reset(1);
    step(1'b1, 32'h8000_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd);
    step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd);

    // Randomized traffic with held requests.
    ip = 1'b0; dp = 1'b0; ia = '0; da = '0; dwe = 1'b0; ds = '0; dwd = '0;
    for (int c = 0; c < 400; c++) begin
      if (!ip) begin
        ip = ($urandom_range(0, 3) != 0);
        ia = rnd_addr();
      end
      if (!dp) begin
        dp  = ($urandom_range(0, 2) != 0);
        dwe = 1'($urandom_range(0, 1));
        ds  = 4'($urandom);
        dwd = $urandom;
        da  = rnd_addr();
      end
      step(ip, ia, dp, dwe, ds, dwd, da, gi, gd);
      if (gi) ip = 1'b0;
      if (gd) dp = 1'b0;
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd);
    @(posedge clk);
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
